// File: rtl/taillight_ctrl.sv
// ---------------------------------------------------------------------------
// taillight_ctrl
//   Sequencer in front of taillight_FSM. Conditions the four raw dash switches
//   (2-flop sync + debounce), generates the blink step strobe, and picks the
//   single command (left/right/bk/haz) taillight_FSM sees on each step. Turn
//   sweep changes wait for a frame boundary so a running sweep is never cut.
//
// Ports
//   clk, rst_n                      clock (rising), async active-low reset
//   left_sw/right_sw/bk_sw/haz_sw   raw switches, asynchronous to clk
//   step                            one-cycle strobe every DIV cycles
//   left/right/bk/haz               registered commands, change on steps only
//   frame_start                     pulse on a step where phase wraps to 0
//                                   and the new mode is not OFF
//   phase                           current sweep phase 0..FRAME-1
// ---------------------------------------------------------------------------
module taillight_ctrl #(
    parameter int DIV       = 12_500_000,
    parameter int DB_CYCLES = 250_000,
    parameter int FRAME     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       bk_sw,
    input  logic       haz_sw,
    output logic       step,
    output logic       left,
    output logic       right,
    output logic       bk,
    output logic       haz,
    output logic       frame_start,
    output logic [1:0] phase
);
    localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DCW = $clog2(DB_CYCLES + 1);

    typedef enum logic [2:0] {
        M_OFF, M_LEFT, M_RIGHT, M_BRAKE, M_LBK, M_RBK, M_HAZ
    } mode_t;

    // switch bit order: {haz, bk, right, left}
    logic [3:0]          w_raw;
    logic [3:0]          r_sync1, r_sync2, r_deb;
    logic [3:0][DCW-1:0] r_dbcnt;
    logic [PCW-1:0]      r_cnt;
    mode_t               r_mode, w_req, w_nxt_mode;
    logic [1:0]          r_phase, w_nxt_phase, w_adv;
    logic [3:0]          r_cmd, w_nxt_cmd;
    logic                w_toggle;

    assign w_raw = {haz_sw, bk_sw, right_sw, left_sw};

    // ---------------- input conditioning ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_dbcnt <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 4; i++) begin
                // any agreement restarts the stability count
                if (r_sync2[i] == r_deb[i]) begin
                    r_dbcnt[i] <= '0;
                end else if (r_dbcnt[i] == DCW'(DB_CYCLES - 1)) begin
                    r_deb[i]   <= ~r_deb[i];
                    r_dbcnt[i] <= '0;
                end else begin
                    r_dbcnt[i] <= r_dbcnt[i] + 1'b1;
                end
            end
        end
    end

    // ---------------- prescaler ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    r_cnt <= '0;
        else if (step) r_cnt <= '0;
        else           r_cnt <= r_cnt + 1'b1;
    end

    assign step = (r_cnt == PCW'(DIV - 1));

    // ---------------- request resolve ----------------
    always_comb begin
        w_req = M_OFF;
        if (r_deb[3])                 w_req = M_HAZ;
        else if (r_deb[0] & r_deb[1]) w_req = r_deb[2] ? M_BRAKE : M_OFF;
        else if (r_deb[0] & r_deb[2]) w_req = M_LBK;
        else if (r_deb[1] & r_deb[2]) w_req = M_RBK;
        else if (r_deb[0])            w_req = M_LEFT;
        else if (r_deb[1])            w_req = M_RIGHT;
        else if (r_deb[2])            w_req = M_BRAKE;
    end

    // ---------------- mode / phase next state ----------------
    always_comb begin
        w_nxt_mode  = r_mode;
        w_nxt_phase = r_phase;
        w_adv       = (r_phase == 2'(FRAME - 1)) ? 2'd0 : r_phase + 2'd1;
        // adding or dropping brake keeps the sweep direction, so no restart
        w_toggle    = ((r_mode == M_LEFT)  && (w_req == M_LBK))  ||
                      ((r_mode == M_LBK)   && (w_req == M_LEFT)) ||
                      ((r_mode == M_RIGHT) && (w_req == M_RBK))  ||
                      ((r_mode == M_RBK)   && (w_req == M_RIGHT));
        if (w_req == r_mode) begin
            // idle stays parked at phase 0
            w_nxt_phase = (r_mode == M_OFF) ? 2'd0 : w_adv;
        end else if ((w_req == M_HAZ) || (r_mode inside {M_OFF, M_BRAKE, M_HAZ})) begin
            w_nxt_mode  = w_req;
            w_nxt_phase = 2'd0;
        end else if (w_toggle) begin
            w_nxt_mode  = w_req;
            w_nxt_phase = w_adv;
        end else if (r_phase == 2'(FRAME - 1)) begin
            // deferred turn change lands on the frame boundary
            w_nxt_mode  = w_req;
            w_nxt_phase = 2'd0;
        end else begin
            w_nxt_phase = w_adv;
        end
    end

    // command decode {haz, bk, right, left}
    always_comb begin
        w_nxt_cmd = 4'b0000;
        case (w_nxt_mode)
            M_LEFT:  w_nxt_cmd = 4'b0001;
            M_RIGHT: w_nxt_cmd = 4'b0010;
            M_BRAKE: w_nxt_cmd = 4'b0100;
            M_LBK:   w_nxt_cmd = 4'b0101;
            M_RBK:   w_nxt_cmd = 4'b0110;
            M_HAZ:   w_nxt_cmd = 4'b1000;
            default: w_nxt_cmd = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= M_OFF;
            r_phase <= 2'd0;
            r_cmd   <= 4'b0000;
        end else if (step) begin
            r_mode  <= w_nxt_mode;
            r_phase <= w_nxt_phase;
            r_cmd   <= w_nxt_cmd;
        end
    end

    assign frame_start = step && (w_nxt_phase == 2'd0) && (w_nxt_mode != M_OFF);
    assign {haz, bk, right, left} = r_cmd;
    assign phase = r_phase;

endmodule

// File: tb/tb_taillight_ctrl.sv
module tb_taillight_ctrl;
    localparam int DIV   = 4;
    localparam int DB    = 3;
    localparam int FRAME = 4;

    // reference model mode names
    localparam int OFF = 0, LFT = 1, RGT = 2, BRK = 3, LBK = 4, RBK = 5, HAZ = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic left_sw = 1'b0, right_sw = 1'b0, bk_sw = 1'b0, haz_sw = 1'b0;
    logic step, left, right, bk, haz, frame_start;
    logic [1:0] phase;

    int n_tests = 0;
    int n_fail  = 0;

    taillight_ctrl #(.DIV(DIV), .DB_CYCLES(DB), .FRAME(FRAME)) dut (
        .clk(clk), .rst_n(rst_n),
        .left_sw(left_sw), .right_sw(right_sw), .bk_sw(bk_sw), .haz_sw(haz_sw),
        .step(step), .left(left), .right(right), .bk(bk), .haz(haz),
        .frame_start(frame_start), .phase(phase)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_cyc;          // rising edges since reset release
    logic [3:0] m_pipe[$];      // raw samples in flight through the synchronizer
    logic [3:0] m_deb;          // {haz,bk,right,left}
    int         m_agree[4];     // last edge where sync matched debounced (or flipped)
    int         m_mode, m_phase;
    logic [3:0] m_s2;

    function automatic int resolve(input logic [3:0] d);
        if (d[3])            return HAZ;
        if (d[0] && d[1])    return d[2] ? BRK : OFF;
        if (d[0] && d[2])    return LBK;
        if (d[1] && d[2])    return RBK;
        if (d[0])            return LFT;
        if (d[1])            return RGT;
        if (d[2])            return BRK;
        return OFF;
    endfunction

    function automatic int dir_of(input int m);
        if (m == LFT || m == LBK) return 1;
        if (m == RGT || m == RBK) return 2;
        return 0;
    endfunction

    function automatic void next_of(input int mode, input int ph, input int req,
                                    output int nm, output int np);
        int adv;
        adv = (ph + 1) % FRAME;
        nm = mode;
        np = adv;
        if (req == mode) begin
            np = (mode == OFF) ? 0 : adv;
        end else if (req == HAZ || mode == OFF || mode == BRK || mode == HAZ) begin
            nm = req; np = 0;
        end else if (dir_of(req) != 0 && dir_of(req) == dir_of(mode)) begin
            nm = req;
        end else if (ph == FRAME - 1) begin
            nm = req; np = 0;
        end
    endfunction

    function automatic logic [3:0] decode(input int m);
        case (m)
            LFT: return 4'b0001;
            RGT: return 4'b0010;
            BRK: return 4'b0100;
            LBK: return 4'b0101;
            RBK: return 4'b0110;
            HAZ: return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc   = 0;
            m_pipe  = {4'b0000, 4'b0000};
            m_deb   = 4'b0000;
            m_mode  = OFF;
            m_phase = 0;
            for (int i = 0; i < 4; i++) m_agree[i] = -1;
        end else begin
            if (m_cyc % DIV == DIV - 1) begin
                int nm, np;
                next_of(m_mode, m_phase, resolve(m_deb), nm, np);
                m_mode = nm;
                m_phase = np;
            end
            m_s2 = m_pipe.pop_front();
            m_pipe.push_back({haz_sw, bk_sw, right_sw, left_sw});
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] == m_deb[i]) m_agree[i] = m_cyc;
                else if (m_cyc - m_agree[i] >= DB) begin
                    m_deb[i] = ~m_deb[i];
                    m_agree[i] = m_cyc;
                end
            end
            m_cyc++;
        end
    end

    function automatic logic [7:0] expected();
        logic st, fs;
        int nm, np;
        st = (m_cyc % DIV == DIV - 1);
        next_of(m_mode, m_phase, resolve(m_deb), nm, np);
        fs = st && np == 0 && nm != OFF;
        return {st, fs, decode(m_mode), 2'(m_phase)};
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one cycle: every negedge compares all outputs with the model
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            check("cycle", {step, frame_start, haz, bk, right, left, phase}, expected());
        end
    endtask

    task automatic wait_cmd(input string tag, input logic [3:0] want, input int budget);
        int k = 0;
        while ({haz, bk, right, left} !== want && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, {4'b0, haz, bk, right, left}, {4'b0, want});
    endtask

    task automatic wait_phase(input string tag, input logic [1:0] want, input int budget);
        int k = 0;
        while (phase !== want && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, {6'b0, phase}, {6'b0, want});
    endtask

    task automatic set_sw(input logic [3:0] v);
        {haz_sw, bk_sw, right_sw, left_sw} = v;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tick(2);
        check("reset_out", {step, frame_start, haz, bk, right, left, phase}, 8'h00);
        rst_n = 1'b1;

        // 1: idle stepping
        tick(20);
        check("idle_cmd", {4'b0, haz, bk, right, left}, 8'h00);

        // 2: glitch rejected, then a real left
        set_sw(4'b0001);
        tick(2);
        set_sw(4'b0000);
        tick(12);
        check("glitch_left", {7'b0, left}, 8'h00);
        set_sw(4'b0001);
        wait_cmd("left_on", 4'b0001, 20);
        tick(16);

        // 3: deferred left -> right
        wait_phase("l_ph1", 2'd1, 8);
        set_sw(4'b0010);
        wait_cmd("to_right", 4'b0010, 40);
        check("right_ph0", {6'b0, phase}, 8'h00);
        tick(8);

        // 4: brake toggle within a left sweep
        set_sw(4'b0001);
        wait_cmd("left_again", 4'b0001, 40);
        wait_phase("l_ph2", 2'd2, 16);
        set_sw(4'b0101);
        wait_cmd("lbk", 4'b0101, 20);
        set_sw(4'b0001);
        wait_cmd("lbk_drop", 4'b0001, 20);

        // 5: hazard overrides right immediately
        set_sw(4'b0010);
        wait_cmd("right_again", 4'b0010, 40);
        wait_phase("r_ph1", 2'd1, 16);
        set_sw(4'b1010);
        wait_cmd("haz_on", 4'b1000, 20);
        check("haz_ph0", {6'b0, phase}, 8'h00);
        set_sw(4'b0010);
        wait_cmd("haz_off", 4'b0010, 20);
        check("haz_off_ph0", {6'b0, phase}, 8'h00);

        // 6: reset mid-frame
        set_sw(4'b0101);
        wait_cmd("lbk_pre_rst", 4'b0101, 60);
        tick(1);
        rst_n = 1'b0;
        #1;
        check("rst_async", {step, frame_start, haz, bk, right, left, phase}, 8'h00);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        check("post_rst_cmd", {4'b0, haz, bk, right, left}, 8'h00);
        wait_cmd("post_rst_lbk", 4'b0101, 20);

        // random switch traffic with occasional reset
        for (int r = 0; r < 120; r++) begin
            set_sw(4'($urandom_range(0, 15)) & (($urandom_range(0, 3) == 0) ? 4'hF : 4'h7));
            tick($urandom_range(1, 30));
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
        end
        tick(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
